// File: rtl/add_nibble_seq_if.sv
// Operand/result bundle for add_nibble_seq: valid/ready on the operand side and on the result side.
// master drives operands and consumes results; slave is the adder.
interface add_nibble_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, op_sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, zero, busy
    );

    modport slave (
        input  in_valid, a, b, ci, op_sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, zero, busy
    );
endinterface

// File: rtl/add_nibble_seq.sv
// WIDTH-bit add/sub through one 4-bit slice, LSB nibble first; result valid WIDTH/4+1 cycles after acceptance.
// Operands taken only in IDLE; the result is held in DONE until out_ready, then one idle cycle before the next accept.
module add_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    add_nibble_seq_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             co_r, ovf_r, zero_r;
    logic [3:0]       sl_s;
    logic             sl_co;
    logic             rip_c;
    logic             last;
    logic             in_rdy, out_vld, busy_i;
    logic             accept;

    // 4-bit ripple slice over the low nibbles of the shift registers
    always_comb begin
        rip_c = carry;
        sl_s  = '0;
        for (int i = 0; i < 4; i++) begin
            sl_s[i] = a_sh[i] ^ b_sh[i] ^ rip_c;
            rip_c   = (a_sh[i] & b_sh[i]) | (rip_c & (a_sh[i] ^ b_sh[i]));
        end
        sl_co = rip_c;
    end

    assign last    = (cnt == CW'(NIB - 1));
    assign sum_nxt = (sum_r >> 4) | (WIDTH'(sl_s) << (WIDTH - 4));
    assign accept  = bus.in_valid & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        busy_i  = 1'b0;
        case (state)
            IDLE:    in_rdy = 1'b1;
            RUN:     busy_i = 1'b1;
            DONE: begin
                out_vld = 1'b1;
                busy_i  = 1'b1;
            end
            default: in_rdy = 1'b0;
        endcase
    end

    // Subtraction is a + ~b + ~borrow; the last-nibble msbs are the original operand msbs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub ? ~bus.ci : bus.ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            carry <= sl_co;
            cnt   <= cnt + CW'(1);
            sum_r <= sum_nxt;
            if (last) begin
                co_r   <= sl_co;
                ovf_r  <= (a_sh[3] == b_sh[3]) && (sl_s[3] != a_sh[3]);
                zero_r <= (sum_nxt == '0);
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.busy      = busy_i;
    assign bus.sum       = sum_r;
    assign bus.co        = co_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_add_nibble_seq.sv
// Bench for add_nibble_seq: directed cases from the datasheet plus random traffic against an arithmetic model.
module tb_add_nibble_seq;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_nibble_seq_if #(.WIDTH(WIDTH)) bus();
    add_nibble_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    task automatic check_word(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer add/sub with range checks for carry and signed overflow
    function automatic void ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sub,
                                   output logic [WIDTH-1:0] s, output logic c,
                                   output logic o, output logic z);
        longint ua, ub, sa, sb, cin, r, sr;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cin = longint'(ci);
        if (sub) begin
            r  = ua - ub - cin;
            sr = sa - sb - cin;
            c  = (r >= 0);
        end else begin
            r  = ua + ub + cin;
            sr = sa + sb + cin;
            c  = (r >= (longint'(1) << WIDTH));
        end
        s = r[WIDTH-1:0];
        o = (sr > ((longint'(1) << (WIDTH - 1)) - 1)) || (sr < -(longint'(1) << (WIDTH - 1)));
        z = (s == '0);
    endfunction

    // Model: cyc = 0 idle, 1..NIB computing, NIB+1 result presented
    int               cyc = 0;
    bit               started = 0;
    logic [WIDTH-1:0] e_sum, p_sum;
    logic             e_co, e_ovf, e_zero, p_co, p_ovf, p_zero;

    always @(posedge clk) begin
        cyc_no++;
        if (rst) begin
            started = 1;
            cyc     = 0;
            e_sum   = '0;
            e_co    = 1'b0;
            e_ovf   = 1'b0;
            e_zero  = 1'b0;
        end else if (started) begin
            if (cyc == 0) begin
                if (bus.in_valid) begin
                    ref_op(bus.a, bus.b, bus.ci, bus.op_sub, p_sum, p_co, p_ovf, p_zero);
                    cyc = 1;
                end
            end else if (cyc <= NIB) begin
                cyc++;
                if (cyc == NIB + 1) begin
                    e_sum  = p_sum;
                    e_co   = p_co;
                    e_ovf  = p_ovf;
                    e_zero = p_zero;
                end
            end else if (bus.out_ready) begin
                cyc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check_bit("in_ready", bus.in_ready, cyc == 0);
            check_bit("out_valid", bus.out_valid, cyc == NIB + 1);
            check_bit("busy", bus.busy, cyc != 0);
            if (cyc == 0 || cyc == NIB + 1) begin
                check_word("sum", bus.sum, e_sum);
                check_bit("co", bus.co, e_co);
                check_bit("ovf", bus.ovf, e_ovf);
                check_bit("zero", bus.zero, e_zero);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input logic sub, input logic [WIDTH-1:0] xs,
                          input logic xc, input logic xo, input logic xz);
        int n;
        bus.a         = a;
        bus.b         = b;
        bus.ci        = ci;
        bus.op_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check_int({nm, " latency"}, n, NIB + 1);
        check_word({nm, " sum"}, bus.sum, xs);
        check_bit({nm, " co"}, bus.co, xc);
        check_bit({nm, " ovf"}, bus.ovf, xo);
        check_bit({nm, " zero"}, bus.zero, xz);
        tick();
        check_bit({nm, " in_ready after"}, bus.in_ready, 1'b1);
    endtask

    logic [WIDTH-1:0] sp [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    function automatic logic [WIDTH-1:0] rnd_opnd();
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
        return WIDTH'($urandom);
    endfunction

    initial begin
        int acc [3];
        int k;
        logic [WIDTH-1:0] sa [3];
        logic [WIDTH-1:0] sb [3];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.op_sub    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_bit("reset in_ready", bus.in_ready, 1'b1);
        check_bit("reset out_valid", bus.out_valid, 1'b0);
        check_word("reset sum", bus.sum, 16'h0000);
        check_bit("reset co", bus.co, 1'b0);
        check_bit("reset zero", bus.zero, 1'b0);
        check_bit("reset busy", bus.busy, 1'b0);

        run_op("add",     16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("ovf add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub brw", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);

        // Backpressure with junk on the operand side while computing
        bus.out_ready = 1'b0;
        bus.a = 16'h1234; bus.b = 16'h0FFF; bus.ci = 1'b0; bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            bus.op_sub = 1'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            check_bit("hold out_valid", bus.out_valid, 1'b1);
            check_word("hold sum", bus.sum, 16'h2233);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_bit("release in_ready", bus.in_ready, 1'b1);
        check_bit("release out_valid", bus.out_valid, 1'b0);

        // Reset in the second computing cycle
        bus.a = 16'h1111; bus.b = 16'h2222; bus.ci = 1'b0; bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("abort in_ready", bus.in_ready, 1'b1);
        check_bit("abort out_valid", bus.out_valid, 1'b0);
        check_word("abort sum", bus.sum, 16'h0000);
        repeat (6) tick();
        run_op("after abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        // Streaming with in_valid held high
        sa = '{16'h0100, 16'hABCD, 16'h8000};
        sb = '{16'h0023, 16'h1111, 16'h8000};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = sa[i];
            bus.b = sb[i];
            k = 0;
            @(negedge clk);
            while (!bus.in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            acc[i] = cyc_no;
            tick();
        end
        bus.in_valid = 1'b0;
        check_int("stream gap 1", acc[1] - acc[0], NIB + 2);
        check_int("stream gap 2", acc[2] - acc[1], NIB + 2);
        repeat (8) tick();
        check_word("stream last sum", bus.sum, 16'h0000);
        check_bit("stream last co", bus.co, 1'b1);
        check_bit("stream last ovf", bus.ovf, 1'b1);

        // Random traffic including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.a         = rnd_opnd();
            bus.b         = rnd_opnd();
            bus.ci        = 1'($urandom);
            bus.op_sub    = 1'($urandom);
            tick();
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
